// File: rtl/mpy_result_accumulator_if.sv
// Product-in / result-out bundle for the multiplier result accumulator.
// master = product source and result consumer (testbench / upstream glue),
// slave  = the accumulator itself.
interface mpy_result_accumulator_if #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output in_valid, product, last, out_ready,
        input  in_ready, out_valid, acc_out, count, overflow
    );

    modport slave (
        input  in_valid, product, last, out_ready,
        output in_ready, out_valid, acc_out, count, overflow
    );
endinterface

// File: rtl/mpy_result_accumulator.sv
// Signed burst accumulator behind the 32x32 multiplier.
// Sums a burst of two's-complement products into a saturating wide
// accumulator and presents the total, term count and a sticky overflow
// flag through a valid/ready handshake. A burst closes on 'last' or on
// the MAX_TERMS-th accepted term, whichever comes first.
module mpy_result_accumulator #(
    parameter int PROD_W    = 64,
    parameter int ACC_W     = 72,
    parameter int CNT_W     = 16,
    parameter int MAX_TERMS = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    mpy_result_accumulator_if.slave      bus
);

    // Term index at which an accepted beat closes the burst on its own.
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_TERMS - 1);
    // Sign-extension bits needed to lift a product to the ACC_W+1 sum width.
    localparam int EXT_W = ACC_W + 1 - PROD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // True when an ACC_W+1 bit sum no longer fits the ACC_W signed range.
    function automatic logic sum_overflows(input logic [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    // Clamp an ACC_W+1 bit sum to the most positive / most negative value.
    function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W:0] s);
        logic [ACC_W-1:0] r;
        if (sum_overflows(s)) begin
            if (s[ACC_W]) begin
                r = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                r = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            r = s[ACC_W-1:0];
        end
        return r;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [ACC_W-1:0]   acc_r, acc_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               ovf_r, ovf_nxt_s;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               accept_s;
    logic               closing_s;
    logic [ACC_W:0]     sum_s;

    // Next-state, accumulate and saturate logic; clr overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        accept_s    = bus.in_valid & in_ready_r;
        closing_s   = bus.last | (count_r == LIMIT_CNT);
        sum_s       = {acc_r[ACC_W-1], acc_r}
                    + {{EXT_W{bus.product[PROD_W-1]}}, bus.product};

        if (clr) begin
            state_nxt_s = ST_IDLE;
            acc_nxt_s   = {ACC_W{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACC: begin
                    if (accept_s) begin
                        acc_nxt_s   = saturate(sum_s);
                        count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        ovf_nxt_s   = ovf_r | sum_overflows(sum_s);
                        if (closing_s) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            state_nxt_s = ST_ACC;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_nxt_s = ST_IDLE;
                        acc_nxt_s   = {ACC_W{1'b0}};
                        count_nxt_s = {CNT_W{1'b0}};
                        ovf_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    acc_nxt_s   = {ACC_W{1'b0}};
                    count_nxt_s = {CNT_W{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and handshake registers; handshake flags follow next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {ACC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            count_r     <= count_nxt_s;
            ovf_r       <= ovf_nxt_s;
            out_valid_r <= (state_nxt_s == ST_HOLD);
            in_ready_r  <= (state_nxt_s != ST_HOLD);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.acc_out   = acc_r;
    assign bus.count     = count_r;
    assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_mpy_result_accumulator.sv
// Bench for mpy_result_accumulator: three configurations (72/256, 66/8,
// 72/4) share one stimulus bus, only the selected one sees in_valid.
// A burst-level reference model with plain wide arithmetic predicts results.
module tb_mpy_result_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        last = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] product = 64'd0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;

    mpy_result_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) if_a ();
    mpy_result_accumulator_if #(.PROD_W(64), .ACC_W(66), .CNT_W(16)) if_b ();
    mpy_result_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) if_c ();

    assign if_a.in_valid = in_valid & (sel == 0);
    assign if_b.in_valid = in_valid & (sel == 1);
    assign if_c.in_valid = in_valid & (sel == 2);
    assign if_a.product = product;
    assign if_b.product = product;
    assign if_c.product = product;
    assign if_a.last = last;
    assign if_b.last = last;
    assign if_c.last = last;
    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;
    assign if_c.out_ready = out_ready;

    mpy_result_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16), .MAX_TERMS(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_a.slave));
    mpy_result_accumulator #(.PROD_W(64), .ACC_W(66), .CNT_W(16), .MAX_TERMS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_b.slave));
    mpy_result_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16), .MAX_TERMS(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_c.slave));

    always #5 clk = ~clk;

    // Observed outputs of the selected configuration, acc sign-extended to 72.
    logic        obs_in_ready, obs_out_valid, obs_ovf;
    logic [15:0] obs_cnt;
    logic [71:0] obs_acc;
    always_comb begin
        obs_in_ready  = if_a.in_ready;
        obs_out_valid = if_a.out_valid;
        obs_ovf       = if_a.overflow;
        obs_cnt       = if_a.count;
        obs_acc       = if_a.acc_out;
        if (sel == 1) begin
            obs_in_ready  = if_b.in_ready;
            obs_out_valid = if_b.out_valid;
            obs_ovf       = if_b.overflow;
            obs_cnt       = if_b.count;
            obs_acc       = {{6{if_b.acc_out[65]}}, if_b.acc_out};
        end else if (sel == 2) begin
            obs_in_ready  = if_c.in_ready;
            obs_out_valid = if_c.out_valid;
            obs_ovf       = if_c.overflow;
            obs_cnt       = if_c.count;
            obs_acc       = if_c.acc_out;
        end
    end

    // Reference model state: running saturated sum, term count, sticky flag.
    logic signed [127:0] m_sum;
    int                  m_cnt;
    bit                  m_ovf;
    bit                  m_closed;
    int                  m_acc_w;
    int                  m_max;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sum = 128'sd0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_closed = 1'b0;
    endtask

    task automatic select_cfg(input int s);
        sel = s;
        m_acc_w = (s == 1) ? 66 : 72;
        m_max = (s == 0) ? 256 : ((s == 1) ? 8 : 4);
        model_clear();
    endtask

    task automatic model_add(input logic [63:0] p, input bit l);
        logic signed [127:0] hi, lo, s;
        hi = (128'sd1 <<< (m_acc_w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (m_acc_w - 1));
        s = m_sum + $signed({{64{p[63]}}, p});
        if (s > hi) begin
            s = hi;
            m_ovf = 1'b1;
        end else if (s < lo) begin
            s = lo;
            m_ovf = 1'b1;
        end
        m_sum = s;
        m_cnt++;
        m_closed = l || (m_cnt == m_max);
    endtask

    // Present one product and wait (bounded) until it is accepted.
    task automatic send(input logic [63:0] p, input bit l);
        int n;
        n = 0;
        in_valid = 1'b1;
        product = p;
        last = l;
        while (!obs_in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("in_ready_wait", {127'd0, obs_in_ready}, 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        last = 1'b0;
        model_add(p, l);
    endtask

    // Check the held result, optionally stall the consumer, then take it.
    task automatic check_result(input int hold);
        chk("out_valid", {127'd0, obs_out_valid}, 128'd1);
        chk("acc_out", {56'd0, obs_acc}, {56'd0, m_sum[71:0]});
        chk("count", {112'd0, obs_cnt}, 128'(m_cnt));
        chk("overflow", {127'd0, obs_ovf}, {127'd0, m_ovf});
        chk("in_ready_hold", {127'd0, obs_in_ready}, 128'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            product = {$urandom, $urandom};
            last = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", {127'd0, obs_out_valid}, 128'd1);
            chk("stall_acc", {56'd0, obs_acc}, {56'd0, m_sum[71:0]});
            chk("stall_count", {112'd0, obs_cnt}, 128'(m_cnt));
            chk("stall_in_ready", {127'd0, obs_in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_valid", {127'd0, obs_out_valid}, 128'd0);
        chk("drain_in_ready", {127'd0, obs_in_ready}, 128'd1);
        chk("drain_count", {112'd0, obs_cnt}, 128'd0);
        model_clear();
    endtask

    task automatic rand_burst(input int maxlen);
        int len;
        int r;
        logic [63:0] p;
        len = int'($urandom_range(maxlen, 1));
        for (int i = 1; i <= len; i++) begin
            r = int'($urandom_range(3, 0));
            if (r == 0) p = 64'h7FFF_FFFF_FFFF_FFFF;
            else if (r == 1) p = 64'h8000_0000_0000_0000;
            else p = {$urandom, $urandom};
            send(p, i == len);
            if (m_closed) begin
                check_result(int'($urandom_range(3, 0)));
                break;
            end
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        select_cfg(0);
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {127'd0, obs_in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, obs_out_valid}, 128'd0);
        chk("rst_acc", {56'd0, obs_acc}, 128'd0);
        chk("rst_count", {112'd0, obs_cnt}, 128'd0);
        chk("rst_ovf", {127'd0, obs_ovf}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic burst 5, -7, 100 with consumer already ready
        out_ready = 1'b1;
        send(64'd5, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        send(64'd100, 1'b1);
        chk("basic_acc98", {56'd0, obs_acc}, 128'd98);
        check_result(0);

        // Two 2^62 products: sum 2^63 without 64-bit wrap
        send(64'h4000_0000_0000_0000, 1'b0);
        send(64'h4000_0000_0000_0000, 1'b1);
        chk("no_wrap", {56'd0, obs_acc}, {56'd0, 72'h00_8000_0000_0000_0000});
        check_result(0);

        // Saturation in the 66-bit / 8-term configuration
        select_cfg(1);
        for (int i = 1; i <= 5; i++) send(64'h7FFF_FFFF_FFFF_FFFF, i == 5);
        chk("sat_ovf", {127'd0, obs_ovf}, 128'd1);
        check_result(0);
        send(64'd3, 1'b1);
        check_result(0);

        // Term limit in the 4-term configuration, held with in_valid high
        select_cfg(2);
        for (int i = 0; i < 4; i++) send(64'd1, 1'b0);
        chk("limit_valid", {127'd0, obs_out_valid}, 128'd1);
        chk("limit_acc", {56'd0, obs_acc}, 128'd4);
        chk("limit_count", {112'd0, obs_cnt}, 128'd4);
        in_valid = 1'b1;
        product = 64'd1;
        last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("limit_in_ready", {127'd0, obs_in_ready}, 128'd0);
            chk("limit_hold_cnt", {112'd0, obs_cnt}, 128'd4);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("limit_release", {127'd0, obs_out_valid}, 128'd0);
        chk("limit_release_cnt", {112'd0, obs_cnt}, 128'd0);
        model_clear();
        send(64'd1, 1'b0);
        send(64'd1, 1'b1);
        check_result(0);

        // Backpressure: five stalled cycles
        select_cfg(0);
        send(64'd123, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FF00, 1'b1);
        check_result(5);

        // Synchronous abort with a simultaneous valid beat
        send(64'd10, 1'b0);
        send(64'd20, 1'b0);
        clr = 1'b1;
        in_valid = 1'b1;
        product = 64'd99;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", {112'd0, obs_cnt}, 128'd0);
        chk("clr_acc", {56'd0, obs_acc}, 128'd0);
        chk("clr_in_ready", {127'd0, obs_in_ready}, 128'd1);
        model_clear();
        send(64'd7, 1'b1);
        check_result(0);

        // Asynchronous reset mid-burst
        send(64'd11, 1'b0);
        send(64'd22, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", {112'd0, obs_cnt}, 128'd0);
        chk("arst_acc", {56'd0, obs_acc}, 128'd0);
        chk("arst_in_ready", {127'd0, obs_in_ready}, 128'd1);
        #12;
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("arst_no_valid", {127'd0, obs_out_valid}, 128'd0);
        end

        // Randomized bursts on every configuration
        for (int s = 0; s < 3; s++) begin
            select_cfg(s);
            repeat (8) rand_burst((s == 2) ? 7 : 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpy_result_accumulator.md
Name: mpy_result_accumulator

Overview:
- Downstream consumer of the 32x32 signed multiplier. Accepts its 64-bit two's-complement product stream and sums a burst of products into a wide signed accumulator (dot product / MAC).
- Emits the final sum through a valid/ready handshake.
- Sits between the multiplier output and the result writeback logic. All arithmetic is signed.

Parameters:
- PROD_W, 64: product input width, signed.
- ACC_W, 72: accumulator width, signed; must be >= PROD_W+1.
- CNT_W, 16: term counter width.
- MAX_TERMS, 256: hard burst length limit; burst auto-closes on this term. Range 1..2^CNT_W-1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; discards current burst.
- in_valid  input  1  product word valid.
- in_ready  output  1  block can take a product this cycle.
- product  input  PROD_W  signed product from multiplier.
- last  input  1  marks final product of burst; qualified by accept.
- out_valid  output  1  acc_out/count/overflow valid.
- out_ready  input  1  consumer takes result.
- acc_out  output  ACC_W  signed burst sum.
- count  output  CNT_W  number of terms in burst.
- overflow  output  1  sticky: saturation occurred in this burst.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, count=0, overflow=0, out_valid=0, in_ready=1, acc_out=0.
- accept = in_valid & in_ready. in_ready = 1 in IDLE/ACC, 0 in HOLD. in_ready is a pure function of state, never of in_valid.
- On accept: sum = acc + sign_extend(product) computed at ACC_W+1 bits. count <= count+1.
- Overflow: if sum exceeds ACC_W signed range, acc saturates to +max or -min and overflow <= 1 (sticky until burst ends). Saturated acc continues accumulating normally on later beats.
- States:
  - IDLE (count==0): accept & !last & !limit -> ACC; accept & (last|limit) -> HOLD.
  - ACC: accept & (last|limit) -> HOLD; otherwise stay.
  - HOLD: out_valid=1; acc_out/count/overflow stable; out_ready -> IDLE, clearing acc, count, overflow the same edge.
- limit = (count == MAX_TERMS-1) at accept. The MAX_TERMS-th term closes the burst exactly as last does.
- Latency: out_valid rises on the edge after the closing accept. acc_out includes that final term. Single-term burst: count=1.
- acc_out is registered and tracks acc. Only values during out_valid are meaningful.
- No accept in HOLD. in_valid & last presented during HOLD wait; nothing is dropped or reordered.
- clr (sync, highest priority after reset): state=IDLE, acc=0, count=0, overflow=0, out_valid=0. Any simultaneous accept or out_ready is ignored.
- in_valid low in ACC: state holds indefinitely, no timeout.
- last with in_valid=0 is ignored.
- Reset mid-burst: immediate return to reset values. No partial result is ever presented.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset, then products 5, -7 (0xFFFF_FFFF_FFFF_FFF9), 100 with last on third, out_ready=1 -> one cycle later out_valid=1, acc_out=98, count=3, overflow=0; next edge out_valid=0, in_ready=1.
- Two products 0x4000_0000_0000_0000 (2^62, from (-2^31)^2), last on second -> acc_out=2^63 (0x00_8000_0000_0000_0000 at 72 bits), overflow=0. Confirms no 64-bit wrap.
- ACC_W=66, MAX_TERMS=8, five products 0x7FFF_FFFF_FFFF_FFFF, last on fifth -> acc_out=2^65-1, overflow=1, count=5. Then burst of one product 3 -> acc_out=3, overflow=0.
- MAX_TERMS=4, last never asserted, six consecutive valid products of 1 -> out_valid after fourth, acc_out=4, count=4. in_ready=0 while out_ready held low 3 cycles; fifth/sixth accepted only after release, forming a new burst.
- Backpressure: burst closes with out_ready=0 for 5 cycles -> out_valid, acc_out, count stable all 5 cycles; in_ready=0; in_valid held high gives no accept.
- Abort cases:
  - clr after two products (10, 20) -> IDLE, count=0. Next burst 7 with last -> acc_out=7.
  - rst_n pulse low mid-burst, asynchronous to clk -> outputs at reset values immediately, no out_valid afterwards.
